// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned restoring divider with start/ready handshake and annul.
// Optional macro DIV_RADIX4_EN selects two quotient bits per cycle instead of one.
module div_unit (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        div_start_i,
    input  logic        div_signed_i,
    input  logic        div_annul_i,
    input  logic [31:0] div_opdata1_i,
    input  logic [31:0] div_opdata2_i,
    output logic        div_ready_o,
    output logic [63:0] div_result_o,
    output logic        div_busy_o
);

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_BY_ZERO = 2'd1;
    localparam logic [1:0] ST_ON      = 2'd2;
    localparam logic [1:0] ST_END     = 2'd3;

`ifdef DIV_RADIX4_EN
    localparam logic [5:0] CNT_STEP = 6'd2;
`else
    localparam logic [5:0] CNT_STEP = 6'd1;
`endif

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return 32'd0 - v;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? neg32(v) : v;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        pend_q, pend_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic        sgn_q, sgn_d;
    logic        ready_q, ready_d;
    logic [63:0] result_q, result_d;
    logic        busy_q, busy_d;

    logic [31:0] rem_step_s;
    logic [31:0] quo_step_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

`ifdef DIV_RADIX4_EN
    logic [34:0] part_s, t1_s, t2_s, t3_s;

    // Radix-4 step: pick the largest divisor multiple (3,2,1,0) that keeps the remainder non-negative.
    always_comb begin
        part_s = {1'b0, rem_q, quo_q[31:30]};
        t1_s   = part_s - {3'b000, dvs_q};
        t2_s   = part_s - {2'b00, dvs_q, 1'b0};
        t3_s   = part_s - ({3'b000, dvs_q} + {2'b00, dvs_q, 1'b0});
        if (!t3_s[34]) begin
            rem_step_s = t3_s[31:0];
            quo_step_s = {quo_q[29:0], 2'b11};
        end else if (!t2_s[34]) begin
            rem_step_s = t2_s[31:0];
            quo_step_s = {quo_q[29:0], 2'b10};
        end else if (!t1_s[34]) begin
            rem_step_s = t1_s[31:0];
            quo_step_s = {quo_q[29:0], 2'b01};
        end else begin
            rem_step_s = part_s[31:0];
            quo_step_s = {quo_q[29:0], 2'b00};
        end
    end
`else
    logic [32:0] part_s, t_s;

    // Radix-2 step: shift in the next dividend bit and trial-subtract the divisor once.
    always_comb begin
        part_s = {rem_q, quo_q[31]};
        t_s    = part_s - {1'b0, dvs_q};
        if (!t_s[32]) begin
            rem_step_s = t_s[31:0];
            quo_step_s = {quo_q[30:0], 1'b1};
        end else begin
            rem_step_s = part_s[31:0];
            quo_step_s = {quo_q[30:0], 1'b0};
        end
    end
`endif

    // Sign correction of the magnitude result.
    always_comb begin
        if (sgn_q && (neg_a_q ^ neg_b_q)) begin
            quo_fix_s = neg32(quo_q);
        end else begin
            quo_fix_s = quo_q;
        end
        if (sgn_q && neg_a_q) begin
            rem_fix_s = neg32(rem_q);
        end else begin
            rem_fix_s = rem_q;
        end
    end

    // Next-state logic; the first FREE cycle with start only arms, operands are taken on the next edge.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        sgn_d    = sgn_q;
        ready_d  = ready_q;
        result_d = result_q;
        if (div_annul_i) begin
            state_d  = ST_FREE;
            pend_d   = 1'b0;
            cnt_d    = 6'd0;
            ready_d  = 1'b0;
            result_d = 64'd0;
        end else begin
            case (state_q)
                ST_FREE: begin
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                    if (!div_start_i) begin
                        pend_d = 1'b0;
                    end else if (!pend_q) begin
                        pend_d = 1'b1;
                    end else if (div_opdata2_i == 32'd0) begin
                        pend_d  = 1'b0;
                        state_d = ST_BY_ZERO;
                    end else begin
                        pend_d  = 1'b0;
                        state_d = ST_ON;
                        cnt_d   = 6'd0;
                        rem_d   = 32'd0;
                        quo_d   = abs32(div_opdata1_i, div_signed_i);
                        dvs_d   = abs32(div_opdata2_i, div_signed_i);
                        neg_a_d = div_signed_i & div_opdata1_i[31];
                        neg_b_d = div_signed_i & div_opdata2_i[31];
                        sgn_d   = div_signed_i;
                    end
                end
                ST_BY_ZERO: begin
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                    state_d  = ST_END;
                end
                ST_ON: begin
                    if (cnt_q != 6'd32) begin
                        rem_d = rem_step_s;
                        quo_d = quo_step_s;
                        cnt_d = cnt_q + CNT_STEP;
                    end else begin
                        result_d = {rem_fix_s, quo_fix_s};
                        ready_d  = 1'b1;
                        state_d  = ST_END;
                    end
                end
                ST_END: begin
                    if (div_start_i) begin
                        ready_d  = 1'b1;
                        result_d = result_q;
                    end else begin
                        ready_d  = 1'b0;
                        result_d = 64'd0;
                        state_d  = ST_FREE;
                    end
                end
                default: begin
                    state_d  = ST_FREE;
                    pend_d   = 1'b0;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            endcase
        end
        busy_d = (state_d == ST_BY_ZERO) || (state_d == ST_ON);
    end

    // State and output registers.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q  <= ST_FREE;
            pend_q   <= 1'b0;
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            sgn_q    <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= 64'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            sgn_q    <= sgn_d;
            ready_q  <= ready_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign div_ready_o  = ready_q;
    assign div_result_o = result_q;
    assign div_busy_o   = busy_q;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider that responds to the execute stage's div start/ready handshake. The execute stage is the initiator: it raises start with operands and stalls the pipeline until ready. This block computes quotient and remainder, signed or unsigned, and returns them as a 64-bit {remainder, quotient} word for the HI/LO write path. It also accepts an annul so that a flush can abandon an in-flight division.

## Interface
Parameters: none.
- cpu_clk_50M  in  1  system clock; all state changes on the rising edge
- cpu_rst_n  in  1  asynchronous, active-low reset
- div_start_i  in  1  initiator request; held high until div_ready_o is seen
- div_signed_i  in  1  1 = DIV (two's complement), 0 = DIVU
- div_annul_i  in  1  synchronous abort; highest priority after reset
- div_opdata1_i  in  32  dividend; sampled only on FREE→ON or FREE→BY_ZERO
- div_opdata2_i  in  32  divisor; sampled at the same edge as the dividend
- div_ready_o  out  1  result valid
- div_result_o  out  64  [63:32] remainder (to HI), [31:0] quotient (to LO)
- div_busy_o  out  1  high in states BY_ZERO and ON

## Operation
- Reset: state = FREE, div_ready_o = 0, div_result_o = 0, div_busy_o = 0. Internal counter and operand registers are cleared.
- Annul: when div_annul_i = 1 in any state, the next state is FREE with ready = 0 and result = 0. Annul overrides start.
- FREE:
  - If start = 1 and divisor = 0: go to BY_ZERO.
  - If start = 1 and divisor ≠ 0: latch |dividend|, |divisor|, sign of dividend, sign of divisor and div_signed_i; clear cnt; go to ON.
  - Absolute value is taken only when signed = 1. |0x80000000| = 0x80000000, interpreted as unsigned 2^31.
- BY_ZERO: on the next edge, result = 0, ready = 1, go to END.
- ON: one restoring-division step per cycle.
  - Shift partial remainder and dividend left.
  - Trial-subtract the divisor. If the difference is non-negative, keep it and set the quotient bit to 1; otherwise set the quotient bit to 0.
  - Add the step width to cnt.
  - Input changes, including start, are ignored in this state.
- Completion: on the edge where cnt reaches 32, register the sign-corrected result and ready = 1, and go to END.
  - Sign correction applies only when signed = 1.
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend was negative.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps) and remainder 0. No exception is raised.
- END: ready and result are held while start = 1. When start = 0, the next state is FREE with ready = 0 and result = 0.
- Handshake contract: the initiator drops start combinationally in the cycle ready is high. A back-to-back division therefore passes through one FREE cycle before restarting.

## Timing
- Edge 0 is the first edge at which FREE samples start = 1.
- Radix-2 build: ON begins at edge 1, edges 2–33 perform the 32 steps, and ready rises after edge 34. Stall is 34 cycles.
- Radix-4 build: 16 steps, and ready rises after edge 18. Stall is 18 cycles.
- Divide by zero: ready rises after edge 2 in both builds.
- ready drops one edge after start is sampled low in END.
- div_result_o changes only at completion, at reset/annul, or on END→FREE; it never toggles mid-computation.
- Reset asserted mid-operation clears all outputs immediately (asynchronous).
- Annul asserted mid-operation: ready and result are 0 after the next edge, and a new start is accepted at the following edge.

## Configuration
- DIV_RADIX4_EN defined:
  - Two quotient bits per cycle.
  - Trial subtracts divisor×1, ×2 and ×3 in 35-bit arithmetic, choosing the largest non-negative result.
  - cnt steps by 2.
  - 18-cycle latency.
- DIV_RADIX4_EN undefined:
  - One bit per cycle.
  - Single 33-bit trial subtract.
  - cnt steps by 1.
  - 34-cycle latency.
- Results are bit-identical in both builds.

## Test plan
- Signed 100 / 7, start held until ready: result {0x00000002, 0x0000000E}. Ready rises exactly 34 cycles after start (18 with DIV_RADIX4_EN). busy is high throughout.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat as unsigned 0xFFFFFFFF / 2: quotient 0x7FFFFFFF, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, no hang.
- Divisor 0, start high: ready after 2 cycles with result 0. Drop start: ready = 0 one cycle later, state is FREE.
- Annul at cycle 10 of a division: ready never rises and result stays 0. A following 9 / 3 then gives quotient 3, remainder 0, at normal latency.
- Reset pulsed at cycle 20 of a division: all outputs are 0 immediately. After release, a new division completes correctly. Separately, ready is held while start stays high in END, then clears after start drops.
